// File: rtl/rv4028_bus_bridge.sv
// rtl/rv4028_bus_bridge.sv - CPU strobe bus to single-request memory port bridge
// Decodes 16-bit CPU cycles into mem_req/mem_ack handshakes with a timeout fallback.
module rv4028_bus_bridge #(
    parameter int ADDR_BITS = 24,
    parameter int TIMEOUT   = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          addr,
    input  logic                 req_n,
    input  logic                 rd_n,
    input  logic                 wr_n,
    input  logic                 iorq_n,
    input  logic [1:0]           msk_n,
    input  logic [15:0]          data_in,
    output logic [15:0]          data_out,
    output logic                 data_oe,
    output logic                 wait_n,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [ADDR_BITS-2:0] mem_addr,
    output logic [1:0]           mem_be,
    output logic [15:0]          mem_wdata,
    input  logic                 mem_ack,
    input  logic [15:0]          mem_rdata
);

    localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] cnt;
    logic             rd_q;
    logic             abort_q;
    logic [15:0]      rdata_q;
    logic             cyc_valid;
    logic             in_range;
    logic             finish;

    assign cyc_valid = !req_n && iorq_n && (rd_n != wr_n) && (msk_n != 2'b11);
    assign in_range  = (addr >> ADDR_BITS) == 32'd0;
    assign finish    = mem_ack || (cnt == CNT_MAX);
    assign data_out  = rdata_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        wait_n   = 1'b1;
        data_oe  = 1'b0;
        case (state)
            IDLE: begin
                if (cyc_valid) begin
                    state_nx = in_range ? ACCESS : DONE;
                    wait_n   = !in_range;
                end
            end
            ACCESS: begin
                wait_n = 1'b0;
                // A cycle the CPU walked away from must not land in DONE and drive the pads.
                if (finish) begin
                    state_nx = (abort_q || req_n) ? IDLE : DONE;
                end
            end
            DONE: begin
                data_oe = rd_q && !req_n && !rd_n;
                if (req_n) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
        if (rst) begin
            wait_n = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= 2'b00;
            mem_wdata <= 16'h0000;
            cnt       <= '0;
            rd_q      <= 1'b0;
            abort_q   <= 1'b0;
            rdata_q   <= 16'h0000;
        end else begin
            case (state)
                IDLE: begin
                    if (cyc_valid) begin
                        rd_q    <= !rd_n;
                        abort_q <= 1'b0;
                        cnt     <= '0;
                        if (in_range) begin
                            mem_req   <= 1'b1;
                            mem_we    <= !wr_n;
                            mem_addr  <= addr[ADDR_BITS-1:1];
                            mem_be    <= ~msk_n;
                            mem_wdata <= data_in;
                        end else if (!rd_n) begin
                            rdata_q <= 16'hFFFF;
                        end
                    end
                end
                ACCESS: begin
                    if (req_n) begin
                        abort_q <= 1'b1;
                    end
                    // An ack on the final counted cycle still wins over the timeout.
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        if (rd_q) begin
                            rdata_q <= mem_rdata;
                        end
                    end else if (cnt == CNT_MAX) begin
                        mem_req <= 1'b0;
                        if (rd_q) begin
                            rdata_q <= 16'hFFFF;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/rv4028_bus_bridge.md
RV4028_BUS_BRIDGE -- requirements
Module: rv4028_bus_bridge

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 24: byte-address bits decoded to the memory port.
REQ-002 SHALL have parameter TIMEOUT, default 255: maximum cycles spent waiting for mem_ack.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 addr  input  32  CPU byte address; bit 0 is always 0.
REQ-006 req_n, rd_n, wr_n, iorq_n  input  1 each  CPU bus strobes, active low.
REQ-007 msk_n  input  2  byte lanes, active low; bit 1 = data[15:8].
REQ-008 data_in  input  16  CPU write data.
REQ-009 data_out  output  16  read data to CPU.
REQ-010 data_oe  output  1  enable for the data_out pad driver.
REQ-011 wait_n  output  1  low stalls the CPU.
REQ-012 mem_req  output  1  memory request, held until accepted.
REQ-013 mem_we  output  1  1 = write.
REQ-014 mem_addr  output  ADDR_BITS-1  16-bit word address, addr[ADDR_BITS-1:1].
REQ-015 mem_be  output  2  byte enables, equal to ~msk_n.
REQ-016 mem_wdata  output  16  write data.
REQ-017 mem_ack  input  1  one-cycle acceptance/completion pulse.
REQ-018 mem_rdata  input  16  read data, valid with mem_ack.

Function
REQ-019 Valid memory cycle: req_n=0, iorq_n=1, exactly one of rd_n/wr_n=0, and msk_n!=2'b11.
REQ-020 In-range means addr[31:ADDR_BITS]==0; other cycle types are ignored: no mem_req, wait_n=1, data_oe=0.
REQ-021 Rd_n and wr_n both low is ignored, as in REQ-020.
REQ-022 States SHALL be IDLE, ACCESS, DONE.
REQ-023 IDLE, valid in-range cycle: latch addr, msk_n, data_in and rd/wr into the mem_* outputs, and go to ACCESS.
REQ-024 IDLE, valid out-of-range cycle: latch read data 16'hFFFF, discard writes, and go directly to DONE.
REQ-025 wait_n is combinational: 0 in IDLE while a valid in-range cycle is presented; 0 throughout ACCESS; 1 otherwise.
REQ-026 ACCESS: mem_req=1 with mem_addr, mem_be, mem_we and mem_wdata stable.
REQ-027 ACCESS: count cycles from 0, starting on the first ACCESS cycle.
REQ-028 On mem_ack in ACCESS: latch mem_rdata for reads, drop mem_req the next cycle, and go to DONE.
REQ-029 If the count reaches TIMEOUT without mem_ack: drop mem_req, latch 16'hFFFF for reads, and go to DONE.
REQ-030 mem_ack outside ACCESS SHALL be ignored.
REQ-031 DONE: data_oe = latched read-flag AND req_n==0 AND rd_n==0, with data_out = latched data.
REQ-032 DONE: return to IDLE on the first cycle with req_n=1.
REQ-033 A new cycle SHALL NOT start until IDLE is reached, so back-to-back transactions need req_n high for at least one cycle.
REQ-034 If req_n rises during ACCESS: keep mem_req until mem_ack or timeout, then go to IDLE directly, with data_oe never asserted.
REQ-035 Latency: an in-range read with mem_ack in the first ACCESS cycle releases wait_n after 2 clock edges from the request.

Reset
REQ-036 On rst=1, immediately: state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_be=0, mem_wdata=0, data_out=0, data_oe=0, counter=0.
REQ-037 wait_n=1 while rst=1, regardless of bus inputs.
REQ-038 Reset mid-ACCESS SHALL abandon the transaction; a late mem_ack after reset is ignored.

Verification
REQ-039 Read addr=0x000124, msk_n=00, mem_ack on the 3rd ACCESS cycle with rdata=0xBEEF -> mem_addr=0x92, mem_be=11, wait_n low for 4 cycles, data_out=0xBEEF with data_oe=1 until req_n rises.
REQ-040 Write addr=0x000010, msk_n=10, data_in=0x5A3C -> mem_we=1, mem_be=01, mem_wdata=0x5A3C, data_oe never 1.
REQ-041 Read addr=0x01000000 with ADDR_BITS=24 -> no mem_req, wait_n stays 1, data_out=0xFFFF.
REQ-042 Read with mem_ack never asserted and TIMEOUT=4 -> mem_req drops after 5 ACCESS cycles, wait_n rises, data_out=0xFFFF.
REQ-043 Rst pulsed mid-ACCESS, then mem_ack -> mem_req=0 and wait_n=1 at once, ack ignored, state stays IDLE.
REQ-044 Iorq_n=0 or rd_n=wr_n=0 with req_n=0 -> no mem_req, wait_n=1, data_oe=0.
